mux_rr_scheduler: RTL and testbench



---
 rtl/mux_sched_pkg.sv | 16 +
 rtl/mux_rr_pick.sv | 35 +++
 rtl/mux_rr_scheduler.sv | 122 ++++++++++++
 tb/tb_mux_rr_scheduler.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_sched_pkg.sv
// Shared constants and types for the round-robin mux scheduler.
// Holds default sizes, FSM state encoding and the port index type.
package mux_sched_pkg;

    localparam int N_PORTS_DEF   = 8;
    localparam int SEL_W_DEF     = 3;
    localparam int MAX_BURST_DEF = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } sched_state_e;

    typedef logic [SEL_W_DEF-1:0] port_idx_t;

endpackage

// File: rtl/mux_rr_pick.sv
// Rotating priority encoder: first set bit of req_i at or above ptr_i, wrapping.
// Ports: req_i (requests), ptr_i (start index), idx_o (winner), found_o (any set).
module rr_pick
    import mux_sched_pkg::*;
#(
    parameter int N_PORTS = N_PORTS_DEF,
    parameter int SEL_W   = SEL_W_DEF
) (
    input  logic [N_PORTS-1:0] req_i,
    input  logic [SEL_W-1:0]   ptr_i,
    output logic [SEL_W-1:0]   idx_o,
    output logic               found_o
);

    always_comb begin
        int               p;
        logic [SEL_W-1:0] pi;
        p       = 0;
        pi      = '0;
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = 0; i < N_PORTS; i++) begin
            p = int'(ptr_i) + i;
            if (p >= N_PORTS) begin
                p = p - N_PORTS;
            end
            pi = SEL_W'(p);
            if (!found_o && req_i[pi]) begin
                found_o = 1'b1;
                idx_o   = pi;
            end
        end
    end

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin burst scheduler driving the select of an N:1 port mux.
// Ports: clk_i, rst_i (sync, active-high), req_i, ready_i in;
// sel_o, grant_o, valid_o, last_o out (all registered or decoded from regs).
module mux_rr_scheduler
    import mux_sched_pkg::*;
#(
    parameter int N_PORTS   = N_PORTS_DEF,
    parameter int SEL_W     = $clog2(N_PORTS),
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [N_PORTS-1:0] req_i,
    input  logic               ready_i,
    output logic [SEL_W-1:0]   sel_o,
    output logic [N_PORTS-1:0] grant_o,
    output logic               valid_o,
    output logic               last_o
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);
    localparam logic [SEL_W-1:0] TOP_IDX  = SEL_W'(N_PORTS - 1);

    sched_state_e     state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             busy;
    logic             last;
    logic             burst_end;
    logic [SEL_W-1:0] nxt_ptr;
    logic [SEL_W-1:0] idle_idx, end_idx;
    logic             idle_found, end_found;

    assign busy    = (state_q == BUSY);
    assign last    = busy && (cnt_q == LAST_CNT);
    // Explicit wrap keeps non-power-of-two port counts correct.
    assign nxt_ptr = (sel_q == TOP_IDX) ? '0 : sel_q + 1'b1;

    rr_pick #(
        .N_PORTS (N_PORTS),
        .SEL_W   (SEL_W)
    ) u_pick_idle (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .idx_o   (idle_idx),
        .found_o (idle_found)
    );

    // Regrant from the advanced pointer so bursts chain with no gap.
    rr_pick #(
        .N_PORTS (N_PORTS),
        .SEL_W   (SEL_W)
    ) u_pick_end (
        .req_i   (req_i),
        .ptr_i   (nxt_ptr),
        .idx_o   (end_idx),
        .found_o (end_found)
    );

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        burst_end = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (idle_found) begin
                    state_d = BUSY;
                    sel_d   = idle_idx;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                // Final accept wins over a simultaneous withdrawal.
                if (ready_i && last) begin
                    burst_end = 1'b1;
                end else if (!req_i[sel_q]) begin
                    burst_end = 1'b1;
                end else if (ready_i) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (burst_end) begin
                    ptr_d = nxt_ptr;
                    cnt_d = '0;
                    if (end_found) begin
                        sel_d = end_idx;
                    end else begin
                        state_d = IDLE;
                        sel_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid_o = busy;
    assign sel_o   = sel_q;
    assign grant_o = busy ? (N_PORTS'(1) << sel_q) : '0;
    assign last_o  = last;

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Scoreboard bench for mux_rr_scheduler: stimulus queues expected beats,
// a negedge monitor pops one per valid cycle and compares.
module tb_mux_rr_scheduler;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       ready;
    logic [2:0] sel;
    logic [7:0] grant;
    logic       valid;
    logic       last;

    int vectors = 0;
    int errors  = 0;

    typedef struct {
        logic [2:0] sel;
        logic       last;
    } exp_t;

    exp_t  q[$];
    string phase = "reset";

    mux_rr_scheduler dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .req_i   (req),
        .ready_i (ready),
        .sel_o   (sel),
        .grant_o (grant),
        .valid_o (valid),
        .last_o  (last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            exp_t       e;
            logic [7:0] g;
            vectors++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL %s unexpected beat: sel=%0d last=%0b, none required",
                         phase, sel, last);
            end else begin
                e = q.pop_front();
                g = 8'h01 << e.sel;
                if (sel !== e.sel || last !== e.last || grant !== g) begin
                    errors++;
                    $display("FAIL %s beat: got sel=%0d last=%0b grant=%02h, required sel=%0d last=%0b grant=%02h",
                             phase, sel, last, grant, e.sel, e.last, g);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [2:0] s, input logic l);
        exp_t e;
        e.sel  = s;
        e.last = l;
        q.push_back(e);
    endtask

    task automatic chk_zero(input string nm);
        vectors++;
        if (valid !== 1'b0 || last !== 1'b0 || sel !== 3'd0 || grant !== 8'h00) begin
            errors++;
            $display("FAIL %s outputs: got valid=%0b last=%0b sel=%0d grant=%02h, required all 0",
                     nm, valid, last, sel, grant);
        end
    endtask

    task automatic drain(input string nm);
        @(negedge clk);
        #1;
        vectors++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s drain: got %0d beats still pending, required 0",
                     nm, q.size());
            q.delete();
        end
    endtask

    initial begin
        rst   = 1'b1;
        req   = 8'hFF;
        ready = 1'b1;

        // Reset held two cycles, then full rotation with all ports requesting
        phase = "reset";
        step();
        chk_zero("reset_c1");
        step();
        chk_zero("reset_c2");
        phase = "rotate";
        rst   = 1'b0;
        for (int i = 0; i < 33; i++) begin
            push(3'((i / 4) % 8), (i % 4) == 3);
        end
        repeat (33) step();
        drain("rotate");

        // Single requester: port 0 is withdrawn, port 4 then owns the mux
        phase = "single";
        req   = 8'h10;
        for (int i = 0; i < 12; i++) begin
            push(3'd4, (i % 4) == 3);
        end
        repeat (12) step();
        drain("single");

        // Backpressure during port 0 burst
        phase = "bp";
        rst   = 1'b1;
        req   = 8'hFF;
        step();
        chk_zero("bp_reset");
        rst = 1'b0;
        push(3'd0, 1'b0);
        push(3'd0, 1'b0);
        push(3'd0, 1'b0);
        push(3'd0, 1'b0);
        push(3'd0, 1'b0);
        push(3'd0, 1'b0);
        push(3'd0, 1'b1);
        push(3'd1, 1'b0);
        repeat (3) step();
        ready = 1'b0;
        repeat (3) step();
        ready = 1'b1;
        repeat (2) step();
        drain("bp");

        // Withdrawal of port 2 after one accepted beat
        phase = "withdraw";
        rst   = 1'b1;
        step();
        chk_zero("wd_reset");
        rst = 1'b0;
        req = 8'h04;
        push(3'd2, 1'b0);
        push(3'd2, 1'b0);
        push(3'd3, 1'b0);
        push(3'd3, 1'b0);
        push(3'd3, 1'b0);
        push(3'd3, 1'b1);
        push(3'd1, 1'b0);
        repeat (2) step();
        req = 8'h0A;
        repeat (5) step();
        drain("withdraw");

        // Wrap from port 7 to port 0 and back
        phase = "wrap";
        rst   = 1'b1;
        step();
        chk_zero("wrap_reset");
        rst = 1'b0;
        req = 8'h40;
        for (int i = 0; i < 4; i++) push(3'd6, i == 3);
        for (int i = 0; i < 4; i++) push(3'd7, i == 3);
        for (int i = 0; i < 4; i++) push(3'd0, i == 3);
        push(3'd7, 1'b0);
        repeat (4) step();
        req = 8'h81;
        repeat (9) step();
        drain("wrap");

        // Reset mid-burst of port 5, then restart from port 0, then idle
        phase = "midrst";
        rst   = 1'b1;
        step();
        chk_zero("mid_reset0");
        rst = 1'b0;
        req = 8'h20;
        push(3'd5, 1'b0);
        push(3'd5, 1'b0);
        push(3'd0, 1'b0);
        push(3'd0, 1'b0);
        repeat (2) step();
        rst = 1'b1;
        step();
        chk_zero("mid_reset1");
        rst = 1'b0;
        req = 8'hFF;
        repeat (2) step();
        req = 8'h00;
        step();
        chk_zero("idle");
        drain("midrst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
